// File: rtl/bidir_bus_ctrl.sv
// rtl/bidir_bus_ctrl.sv - half-duplex write/read transaction controller for a bidirectional pin macro
module bidir_bus_ctrl #(
    parameter int SIZE   = 8,
    parameter int TA_CYC = 1,
    parameter int RD_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_req,
    input  logic [SIZE-1:0] wr_data,
    output logic            wr_ack,
    input  logic            rd_req,
    output logic            rd_ack,
    output logic [SIZE-1:0] rd_data,
    output logic            rd_vld,
    output logic [SIZE-1:0] bus_oe,
    output logic [SIZE-1:0] bus_dout,
    input  logic [SIZE-1:0] bus_din,
    output logic            bus_dir,
    output logic            busy
);

    localparam int MAXC = (TA_CYC > RD_LAT) ? TA_CYC : RD_LAT;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic [2:0] {IDLE, TURN, WSETUP, WDRIVE, RWAIT, RCAP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            last_gnt, last_gnt_nxt;   // 1 = write was granted last
    logic            dir_valid, dir_valid_nxt;
    logic            pend_wr, pend_wr_nxt;
    logic [SIZE-1:0] bus_oe_nxt, bus_dout_nxt, rd_data_nxt;
    logic            bus_dir_nxt, wr_ack_nxt, rd_ack_nxt, rd_vld_nxt, busy_nxt;
    logic            arb, gnt_wr, gnt_rd, start, start_wr;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        last_gnt_nxt  = last_gnt;
        dir_valid_nxt = dir_valid;
        pend_wr_nxt   = pend_wr;
        bus_oe_nxt    = '0;
        bus_dout_nxt  = bus_dout;
        rd_data_nxt   = rd_data;
        bus_dir_nxt   = bus_dir;
        wr_ack_nxt    = 1'b0;
        rd_ack_nxt    = 1'b0;
        rd_vld_nxt    = 1'b0;
        start         = 1'b0;
        start_wr      = 1'b0;

        arb    = (state == IDLE) || (state == WDRIVE) || (state == RCAP);
        gnt_wr = arb && wr_req && (!rd_req || !last_gnt);
        gnt_rd = arb && rd_req && (!wr_req || last_gnt);

        case (state)
            IDLE, WDRIVE, RCAP: begin
                state_nxt = IDLE;
                if (gnt_wr || gnt_rd) begin
                    last_gnt_nxt  = gnt_wr;
                    dir_valid_nxt = 1'b1;
                    if (dir_valid && (gnt_wr != last_gnt)) begin
                        // Pins stay released while the far end changes direction
                        state_nxt   = TURN;
                        cnt_nxt     = CW'(TA_CYC);
                        pend_wr_nxt = gnt_wr;
                        bus_dir_nxt = gnt_wr;
                    end else begin
                        start    = 1'b1;
                        start_wr = gnt_wr;
                    end
                end
            end
            TURN: begin
                if (cnt == CW'(1)) begin
                    start    = 1'b1;
                    start_wr = pend_wr;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            WSETUP: begin
                state_nxt  = WDRIVE;
                bus_oe_nxt = '1;
            end
            RWAIT: begin
                if (cnt == CW'(1)) state_nxt = RCAP;
                else               cnt_nxt   = cnt - CW'(1);
            end
            default: state_nxt = IDLE;
        endcase

        if (state == RCAP) begin
            rd_data_nxt = bus_din;
            rd_vld_nxt  = 1'b1;
        end

        // Data is loaded one cycle before the pins are enabled so the macro register is ready
        if (start) begin
            if (start_wr) begin
                state_nxt    = WSETUP;
                bus_dout_nxt = wr_data;
                bus_dir_nxt  = 1'b1;
                wr_ack_nxt   = 1'b1;
            end else begin
                state_nxt   = RWAIT;
                cnt_nxt     = CW'(RD_LAT);
                bus_dir_nxt = 1'b0;
                rd_ack_nxt  = 1'b1;
            end
        end

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            last_gnt  <= 1'b0;
            dir_valid <= 1'b0;
            pend_wr   <= 1'b0;
            bus_oe    <= '0;
            bus_dout  <= '0;
            rd_data   <= '0;
            bus_dir   <= 1'b0;
            wr_ack    <= 1'b0;
            rd_ack    <= 1'b0;
            rd_vld    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last_gnt  <= last_gnt_nxt;
            dir_valid <= dir_valid_nxt;
            pend_wr   <= pend_wr_nxt;
            bus_oe    <= bus_oe_nxt;
            bus_dout  <= bus_dout_nxt;
            rd_data   <= rd_data_nxt;
            bus_dir   <= bus_dir_nxt;
            wr_ack    <= wr_ack_nxt;
            rd_ack    <= rd_ack_nxt;
            rd_vld    <= rd_vld_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// tb/tb_bidir_bus_ctrl.sv - scoreboard bench for bidir_bus_ctrl across three timing configurations
module tb_bidir_bus_ctrl;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_req [N];
    logic       rd_req [N];
    logic       wr_ack [N];
    logic       rd_ack [N];
    logic       rd_vld [N];
    logic       bus_dir[N];
    logic       busy   [N];
    logic [7:0] wr_data [N];
    logic [7:0] rd_data [N];
    logic [7:0] bus_oe  [N];
    logic [7:0] bus_dout[N];
    logic [7:0] bus_din [N];

    typedef struct packed {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    exp_t q_wr[N][$];
    exp_t q_ra[N][$];
    exp_t q_rv[N][$];

    int cyc  = 0;
    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ta_of(int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic int rl_of(int i);
        return (i == 0) ? 2 : (i == 1) ? 4 : 1;
    endfunction

    task automatic chk(string name, int i, int got, int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h (cycle %0d)", name, i, got, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int TA = (g == 2) ? 3 : 1;
        localparam int RL = (g == 0) ? 2 : (g == 1) ? 4 : 1;

        bidir_bus_ctrl #(.SIZE(8), .TA_CYC(TA), .RD_LAT(RL)) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_req  (wr_req[g]),
            .wr_data (wr_data[g]),
            .wr_ack  (wr_ack[g]),
            .rd_req  (rd_req[g]),
            .rd_ack  (rd_ack[g]),
            .rd_data (rd_data[g]),
            .rd_vld  (rd_vld[g]),
            .bus_oe  (bus_oe[g]),
            .bus_dout(bus_dout[g]),
            .bus_din (bus_din[g]),
            .bus_dir (bus_dir[g]),
            .busy    (busy[g])
        );

        logic oe_due = 1'b0;

        always @(negedge clk) begin : mon
            exp_t e;
            if (!rst_n) begin
                oe_due <= 1'b0;
            end else begin
                chk("bus_oe", g, int'(bus_oe[g]), oe_due ? 32'hFF : 32'h0);
                if (bus_oe[g] != 8'h00) chk("oe_while_far_owns", g, int'(bus_dir[g]), 1);
                oe_due <= wr_ack[g];
                if (wr_ack[g]) begin
                    if (q_wr[g].size() == 0) chk("wr_ack_unexpected", g, 1, 0);
                    else begin
                        e = q_wr[g].pop_front();
                        chk("wr_ack_cycle", g, cyc, e.cyc);
                        chk("wr_dout", g, int'(bus_dout[g]), int'(e.data));
                        chk("wr_dir", g, int'(bus_dir[g]), 1);
                    end
                end
                if (rd_ack[g]) begin
                    if (q_ra[g].size() == 0) chk("rd_ack_unexpected", g, 1, 0);
                    else begin
                        e = q_ra[g].pop_front();
                        chk("rd_ack_cycle", g, cyc, e.cyc);
                        chk("rd_dir", g, int'(bus_dir[g]), 0);
                    end
                end
                if (rd_vld[g]) begin
                    if (q_rv[g].size() == 0) chk("rd_vld_unexpected", g, 1, 0);
                    else begin
                        e = q_rv[g].pop_front();
                        chk("rd_vld_cycle", g, cyc, e.cyc);
                        chk("rd_data", g, int'(rd_data[g]), int'(e.data));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic start_write(int i, logic [7:0] d, int turn);
        exp_t e;
        wr_data[i] = d;
        wr_req[i]  = 1'b1;
        e.cyc  = cyc + 1 + turn * ta_of(i);
        e.data = d;
        q_wr[i].push_back(e);
    endtask

    task automatic start_read(int i, logic [7:0] d, int turn);
        exp_t e;
        bus_din[i] = d;
        rd_req[i]  = 1'b1;
        e.cyc  = cyc + 1 + turn * ta_of(i);
        e.data = 8'h00;
        q_ra[i].push_back(e);
        e.cyc  = e.cyc + rl_of(i) + 1;
        e.data = d;
        q_rv[i].push_back(e);
    endtask

    // which: 0 = wr_ack, 1 = rd_ack, 2 = rd_vld; returns one cycle after the event
    task automatic wait_evt(int i, int which, string name);
        bit seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            case (which)
                0:       seen = wr_ack[i];
                1:       seen = rd_ack[i];
                default: seen = rd_vld[i];
            endcase
        end
        if (!seen) chk(name, i, 0, 1);
        tick();
    endtask

    initial begin
        exp_t e;
        int   a;
        for (int i = 0; i < N; i++) begin
            wr_req[i]  = 1'b0;
            rd_req[i]  = 1'b0;
            wr_data[i] = 8'h00;
            bus_din[i] = 8'h00;
        end

        idle(3);
        chk("rst_bus_oe",   0, int'(bus_oe[0]),   0);
        chk("rst_bus_dout", 0, int'(bus_dout[0]), 0);
        chk("rst_bus_dir",  0, int'(bus_dir[0]),  0);
        chk("rst_wr_ack",   0, int'(wr_ack[0]),   0);
        chk("rst_rd_ack",   0, int'(rd_ack[0]),   0);
        chk("rst_rd_vld",   0, int'(rd_vld[0]),   0);
        chk("rst_rd_data",  0, int'(rd_data[0]),  0);
        chk("rst_busy",     0, int'(busy[0]),     0);
        rst_n = 1'b1;
        idle(2);

        // first write after reset: no turnaround
        start_write(0, 8'hA5, 0);
        wait_evt(0, 0, "wait_wr_a5");
        wr_req[0] = 1'b0;
        idle(2);

        // write, then read launched during WDRIVE: one turnaround cycle
        start_write(0, 8'h3C, 0);
        wait_evt(0, 0, "wait_wr_3c");
        wr_req[0] = 1'b0;
        start_read(0, 8'h5A, 1);
        wait_evt(0, 1, "wait_rd_ack_5a");
        rd_req[0] = 1'b0;
        wait_evt(0, 2, "wait_rd_vld_5a");
        idle(2);

        // three back-to-back writes; only the first pays turnaround after the read
        start_write(0, 8'h01, 1);
        wait_evt(0, 0, "wait_wr_01");
        start_write(0, 8'h02, 0);
        wait_evt(0, 0, "wait_wr_02");
        start_write(0, 8'h03, 0);
        wait_evt(0, 0, "wait_wr_03");
        wr_req[0] = 1'b0;
        idle(2);

        // reset while pins are driven
        start_write(0, 8'hE7, 0);
        wait_evt(0, 0, "wait_wr_e7");
        #1;
        rst_n     = 1'b0;
        wr_req[0] = 1'b0;
        #1;
        chk("rst_async_oe",  0, int'(bus_oe[0]),  0);
        chk("rst_async_dir", 0, int'(bus_dir[0]), 0);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        start_read(0, 8'hC3, 0);
        wait_evt(0, 1, "wait_rd_ack_c3");
        rd_req[0] = 1'b0;
        wait_evt(0, 2, "wait_rd_vld_c3");
        idle(2);

        // both requests held from reset: W, R, W, R, W
        rst_n = 1'b0;
        idle(2);
        rst_n      = 1'b1;
        wr_data[0] = 8'h77;
        bus_din[0] = 8'h99;
        wr_req[0]  = 1'b1;
        rd_req[0]  = 1'b1;
        a = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            e.cyc = a; e.data = 8'h77;
            q_wr[0].push_back(e);
            if (k < 2) begin
                e.cyc = a + ta_of(0) + 2; e.data = 8'h00;
                q_ra[0].push_back(e);
                e.cyc = e.cyc + rl_of(0) + 1; e.data = 8'h99;
                q_rv[0].push_back(e);
            end
            a = a + 2 * ta_of(0) + rl_of(0) + 3;
        end
        for (int k = 0; k < 3; k++) wait_evt(0, 0, "wait_tie_wr");
        wr_req[0] = 1'b0;
        rd_req[0] = 1'b0;
        idle(3);

        // latency across the other timing configurations
        for (int i = 1; i < N; i++) begin
            start_write(i, 8'h10 + 8'(i), 0);
            wait_evt(i, 0, "sweep_wr1");
            wr_req[i] = 1'b0;
            start_read(i, 8'h80 + 8'(i), 1);
            wait_evt(i, 1, "sweep_rd_ack");
            rd_req[i] = 1'b0;
            wait_evt(i, 2, "sweep_rd_vld");
            start_write(i, 8'h20 + 8'(i), 1);
            wait_evt(i, 0, "sweep_wr2");
            wr_req[i] = 1'b0;
            idle(3);
        end

        for (int i = 0; i < N; i++) begin
            chk("pending_wr",  i, q_wr[i].size(), 0);
            chk("pending_rda", i, q_ra[i].size(), 0);
            chk("pending_rdv", i, q_rv[i].size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
